mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Multi-cycle sequencer for the RV32I core. It replaces per-instruction combinational control with a state machine that steps a shared datapath through fetch, decode, execute, memory and writeback. Instruction memory and data memory share one port, and each access uses a req/ack handshake. Decode encodings (alu_op, wb_sel, l_length, s_length) match the existing single-cycle control unit, so the ALU, LSU and register file are reused unchanged.

Parameters:
- RESET_WAIT, 1, number of IDLE cycles after reset release before the first fetch (range 1..15).

Ports:
- i_clk  in  1  core clock, rising-edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_instr  in  32  IR contents; valid from DECODE onward.
- i_br_less  in  1  comparator less-than result; sampled in EXEC.
- i_br_equal  in  1  comparator equal result; sampled in EXEC.
- i_mem_ack  in  1  one-cycle pulse; the shared memory has completed the current access.
- o_mem_req  out  1  memory request; held high until ack.
- o_addr_sel  out  1  0 = PC drives the memory address, 1 = ALU result drives it.
- o_mem_wren  out  1  store strobe; valid while o_mem_req is high.
- o_ir_wren  out  1  load IR from memory read data.
- o_pc_wren  out  1  update PC.
- o_br_sel  out  1  1 = PC loads the ALU result, 0 = PC loads PC+4.
- o_br_unsigned  out  1  comparator unsigned mode.
- o_rd_wren  out  1  register-file write enable.
- o_op_a_sel  out  1  0 = rs1, 1 = PC.
- o_op_b_sel  out  1  0 = rs2, 1 = immediate.
- o_alu_op  out  4  0000 add, 0001 sub, 0010 slt, 0011 sltu, 0100 xor, 0101 or, 0110 and, 0111 sll, 1000 srl, 1001 sra, 1010 lui.
- o_wb_sel  out  2  00 = ALU, 01 = load data, 10 = PC+4.
- o_l_length  out  3  load funct3.
- o_l_unsigned  out  1  1 for LBU/LHU.
- o_s_length  out  2  store funct3[1:0].
- o_insn_illegal  out  1  one-cycle pulse when an illegal instruction is detected.
- o_instr_done  out  1  one-cycle pulse when an instruction retires.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB. State is held in a register on i_clk and reset asynchronously by i_rst_n.
- Reset: state = IDLE and the wait counter is cleared. All outputs are 0 while i_rst_n is low.
- IDLE: all outputs are 0. After RESET_WAIT cycles go to FETCH.
- FETCH:
  - Drive o_mem_req=1, o_addr_sel=0, o_mem_wren=0.
  - Stay in FETCH until i_mem_ack.
  - In the ack cycle drive o_ir_wren=1, then go to DECODE.
- DECODE: one cycle.
  - Opcode is checked against R, I-IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL.
  - R-type is illegal unless funct7 is 0000000 or 0100000.
  - BRANCH is illegal for funct3 010 and 011.
  - Illegal: pulse o_insn_illegal and go to WB with a no-write flag set (PC+4, no rd write).
  - Legal: go to EXEC.
- EXEC: one cycle.
  - Drive op_a_sel, op_b_sel and alu_op exactly as the single-cycle decode does.
  - BRANCH: register taken = per funct3.
    - beq: equal.
    - bne: not equal.
    - blt, bltu: less.
    - bge, bgeu: not less.
    - o_br_unsigned = funct3[1] during EXEC.
  - JAL and JALR: taken = 1.
  - LOAD and STORE go to MEM. Everything else goes to WB.
- MEM:
  - Drive o_mem_req=1 and o_addr_sel=1. Hold the ALU inputs as in EXEC so the address stays stable.
  - STORE: o_mem_wren=1 and o_s_length = funct3[1:0].
  - LOAD: o_l_length = funct3 and o_l_unsigned = (funct3 is 100 or 101).
  - Stay until i_mem_ack.
  - STORE on ack: o_pc_wren=1, o_br_sel=0, o_instr_done=1, go to FETCH.
  - LOAD on ack: go to WB.
- WB: one cycle.
  - o_pc_wren=1 and o_br_sel = taken.
  - o_rd_wren=1 for R, I-IMM, LOAD, JAL, JALR, LUI and AUIPC, unless the no-write flag is set.
  - o_wb_sel: LOAD = 01, JAL/JALR = 10, otherwise 00.
  - LOAD: l_length and l_unsigned are held from MEM.
  - Pulse o_instr_done and go to FETCH.
- Output defaults: every output not named for a state is 0 in that state. No output is ever X.
- Control hazards:
  - o_mem_wren is never high without o_mem_req.
  - o_rd_wren and o_pc_wren are never high outside WB, or the final cycle of MEM for stores.
- The taken flag and no-write flag are cleared on entry to FETCH.
- Reset mid-access: return to IDLE immediately. A late i_mem_ack in IDLE is ignored.
- i_mem_ack outside FETCH and MEM is ignored.
- Latency with zero-wait memory (ack in the first request cycle):
  - ALU, branch, jump: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each ack delay cycle adds exactly one cycle.

Test Plan:
- Reset release with RESET_WAIT=1 → all outputs are 0 during reset. o_mem_req rises exactly 2 cycles after i_rst_n goes high.
- ADD 0x002081B3, zero-wait → states run FETCH, DECODE, EXEC, WB. In WB: o_rd_wren=1, o_wb_sel=00, o_pc_wren=1, o_br_sel=0. In EXEC: o_alu_op=0000. o_instr_done pulses once.
- LW 0x0000A283 with ack delayed 3 cycles in MEM → o_addr_sel=1 and o_mem_req held for 4 cycles, o_mem_wren=0, o_l_length=010. WB follows with o_wb_sel=01. Total 8 cycles.
- SW 0x0050A223 → in MEM: o_mem_wren=1, o_s_length=10. PC updates in the ack cycle. No WB state and o_rd_wren never asserts.
- BEQ 0x00000463 with i_br_equal=1 → o_br_sel=1 in WB, o_rd_wren=0. With i_br_equal=0 → o_br_sel=0.
- Instruction 0x00000000 → o_insn_illegal pulses in DECODE. WB runs with o_rd_wren=0 and o_br_sel=0. Assert i_rst_n low mid-FETCH → all outputs drop to 0 asynchronously.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
//   Multi-cycle sequencer for the RV32I core. It steps a shared datapath
//   through FETCH, DECODE, EXEC, MEM and WB. Instruction and data accesses
//   share one memory port with a req/ack handshake. The decode encodings match
//   the single-cycle control unit, so the ALU, LSU and register file are
//   reused unchanged.
//
// Parameters
//   RESET_WAIT     IDLE cycles after reset release before the first fetch (1..15)
//
// Ports
//   i_clk          core clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_instr        IR contents, valid from DECODE onward
//   i_br_less      comparator less-than, sampled in EXEC
//   i_br_equal     comparator equal, sampled in EXEC
//   i_mem_ack      one-cycle pulse: current memory access has completed
//   o_mem_req      memory request, held until ack
//   o_addr_sel     0 = PC addresses memory, 1 = ALU result addresses memory
//   o_mem_wren     store strobe, only with o_mem_req
//   o_ir_wren      load IR from memory read data
//   o_pc_wren      update PC
//   o_br_sel       1 = PC loads ALU result, 0 = PC loads PC+4
//   o_br_unsigned  comparator unsigned mode
//   o_rd_wren      register-file write enable
//   o_op_a_sel     0 = rs1, 1 = PC
//   o_op_b_sel     0 = rs2, 1 = immediate
//   o_alu_op       ALU operation code
//   o_wb_sel       00 = ALU, 01 = load data, 10 = PC+4
//   o_l_length     load funct3
//   o_l_unsigned   1 for LBU/LHU
//   o_s_length     store funct3[1:0]
//   o_insn_illegal one-cycle pulse on an illegal instruction
//   o_instr_done   one-cycle pulse when an instruction retires
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
    parameter int unsigned RESET_WAIT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_instr,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    input  logic        i_mem_ack,
    output logic        o_mem_req,
    output logic        o_addr_sel,
    output logic        o_mem_wren,
    output logic        o_ir_wren,
    output logic        o_pc_wren,
    output logic        o_br_sel,
    output logic        o_br_unsigned,
    output logic        o_rd_wren,
    output logic        o_op_a_sel,
    output logic        o_op_b_sel,
    output logic [3:0]  o_alu_op,
    output logic [1:0]  o_wb_sel,
    output logic [2:0]  o_l_length,
    output logic        o_l_unsigned,
    output logic [1:0]  o_s_length,
    output logic        o_insn_illegal,
    output logic        o_instr_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;

    localparam logic [3:0] WAIT_LIMIT = 4'(RESET_WAIT);

    state_t     state, state_next;
    logic [3:0] wait_cnt;
    logic       taken, taken_next;       // PC loads the ALU result in WB
    logic       no_write, no_write_next; // illegal instruction: retire without rd write

    // Instruction fields. Register indices are routed by the datapath, not here.
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       instr_unused;

    assign opcode       = i_instr[6:0];
    assign funct3       = i_instr[14:12];
    assign funct7       = i_instr[31:25];
    assign instr_unused = ^{i_instr[24:15], i_instr[11:7]};

    logic is_r, is_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;

    assign is_r      = (opcode == OP_R);
    assign is_imm    = (opcode == OP_IMM);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);

    logic known_op, insn_illegal, writes_rd, l_unsigned;

    assign known_op     = is_r | is_imm | is_load | is_store | is_branch |
                          is_jal | is_jalr | is_lui | is_auipc;
    // R-type only defines funct7 0000000/0100000; BRANCH has no funct3 010/011.
    assign insn_illegal = !known_op
                        | (is_r && (funct7 != 7'b0000000) && (funct7 != 7'b0100000))
                        | (is_branch && (funct3 == 3'b010 || funct3 == 3'b011));
    assign writes_rd    = is_r | is_imm | is_load | is_jal | is_jalr | is_lui | is_auipc;
    assign l_unsigned   = (funct3 == 3'b100) || (funct3 == 3'b101);

    // Shared R / I-IMM ALU mapping. Bit 30 selects SUB only for R-type (ADDI has
    // no subtract form) and selects SRA/SRAI for both.
    function automatic logic [3:0] arith_alu_op(input logic [2:0] f3,
                                                input logic       alt,
                                                input logic       sub_ok);
        case (f3)
            3'b000:  arith_alu_op = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_alu_op = ALU_SLL;
            3'b010:  arith_alu_op = ALU_SLT;
            3'b011:  arith_alu_op = ALU_SLTU;
            3'b100:  arith_alu_op = ALU_XOR;
            3'b101:  arith_alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_alu_op = ALU_OR;
            default: arith_alu_op = ALU_AND;
        endcase
    endfunction

    // ALU operand/opcode decode, identical to the single-cycle control unit.
    // PC-relative targets (branch, JAL, AUIPC) use PC as operand A; everything
    // except R-type takes the immediate as operand B.
    logic       dec_op_a_sel, dec_op_b_sel;
    logic [3:0] dec_alu_op;

    always_comb begin
        dec_op_a_sel = is_branch | is_jal | is_auipc;
        dec_op_b_sel = !is_r;
        dec_alu_op   = ALU_ADD;
        if (is_r) begin
            dec_alu_op = arith_alu_op(funct3, funct7[5], 1'b1);
        end else if (is_imm) begin
            dec_alu_op = arith_alu_op(funct3, funct7[5], 1'b0);
        end else if (is_lui) begin
            dec_alu_op = ALU_LUI;
        end
    end

    // Branch condition from the comparator; funct3[1] picks unsigned compare.
    logic br_cond;

    always_comb begin
        case (funct3)
            3'b000:         br_cond = i_br_equal;
            3'b001:         br_cond = !i_br_equal;
            3'b100, 3'b110: br_cond = i_br_less;
            3'b101, 3'b111: br_cond = !i_br_less;
            default:        br_cond = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            taken    <= 1'b0;
            no_write <= 1'b0;
        end else begin
            state    <= state_next;
            taken    <= taken_next;
            no_write <= no_write_next;
            if (state == S_IDLE && wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default before the
        // case statement, so no path through this block can infer a latch.
        state_next     = state;
        taken_next     = taken;
        no_write_next  = no_write;
        o_mem_req      = 1'b0;
        o_addr_sel     = 1'b0;
        o_mem_wren     = 1'b0;
        o_ir_wren      = 1'b0;
        o_pc_wren      = 1'b0;
        o_br_sel       = 1'b0;
        o_br_unsigned  = 1'b0;
        o_rd_wren      = 1'b0;
        o_op_a_sel     = 1'b0;
        o_op_b_sel     = 1'b0;
        o_alu_op       = ALU_ADD;
        o_wb_sel       = 2'b00;
        o_l_length     = 3'b000;
        o_l_unsigned   = 1'b0;
        o_s_length     = 2'b00;
        o_insn_illegal = 1'b0;
        o_instr_done   = 1'b0;

        case (state)
            S_IDLE: begin
                if (wait_cnt == WAIT_LIMIT) begin
                    state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ack) begin
                    o_ir_wren  = 1'b1;
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                if (insn_illegal) begin
                    o_insn_illegal = 1'b1;
                    no_write_next  = 1'b1;
                    state_next     = S_WB;
                end else begin
                    state_next = S_EXEC;
                end
            end

            S_EXEC: begin
                o_op_a_sel    = dec_op_a_sel;
                o_op_b_sel    = dec_op_b_sel;
                o_alu_op      = dec_alu_op;
                o_br_unsigned = is_branch & funct3[1];
                taken_next    = is_jal | is_jalr | (is_branch & br_cond);
                state_next    = (is_load | is_store) ? S_MEM : S_WB;
            end

            S_MEM: begin
                // ALU inputs stay as in EXEC so the data address is stable
                // for the whole access.
                o_mem_req  = 1'b1;
                o_addr_sel = 1'b1;
                o_op_a_sel = dec_op_a_sel;
                o_op_b_sel = dec_op_b_sel;
                o_alu_op   = dec_alu_op;
                if (is_store) begin
                    o_mem_wren = 1'b1;
                    o_s_length = funct3[1:0];
                    if (i_mem_ack) begin
                        // Stores retire here; there is nothing to write back.
                        o_pc_wren    = 1'b1;
                        o_instr_done = 1'b1;
                        state_next   = S_FETCH;
                    end
                end else begin
                    o_l_length   = funct3;
                    o_l_unsigned = l_unsigned;
                    if (i_mem_ack) begin
                        state_next = S_WB;
                    end
                end
            end

            S_WB: begin
                o_pc_wren    = 1'b1;
                o_br_sel     = taken;
                o_rd_wren    = writes_rd & !no_write;
                o_instr_done = 1'b1;
                if (is_load) begin
                    o_wb_sel     = 2'b01;
                    o_l_length   = funct3;
                    o_l_unsigned = l_unsigned;
                end else if (is_jal | is_jalr) begin
                    o_wb_sel = 2'b10;
                end
                state_next = S_FETCH;
            end

            default: state_next = S_IDLE;
        endcase

        // Per-instruction flags start clean for every fetch.
        if (state_next == S_FETCH) begin
            taken_next    = 1'b0;
            no_write_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm
//   Self-checking bench for mc_ctrl_fsm. A reference model turns each
//   instruction (plus memory wait counts) into the cycle-by-cycle list of
//   inputs to drive and the full output vector expected in that cycle; the
//   bench plays the list back and compares every cycle, plus the retire
//   latency. Directed cases come first, then randomized instructions.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       mem_req;
        logic       addr_sel;
        logic       mem_wren;
        logic       ir_wren;
        logic       pc_wren;
        logic       br_sel;
        logic       br_unsigned;
        logic       rd_wren;
        logic       op_a_sel;
        logic       op_b_sel;
        logic [3:0] alu_op;
        logic [1:0] wb_sel;
        logic [2:0] l_length;
        logic       l_unsigned;
        logic [1:0] s_length;
        logic       insn_illegal;
        logic       instr_done;
    } ctl_t;

    typedef struct packed {
        logic        ack;
        logic        eq;
        logic        lt;
        logic [31:0] instr;
        ctl_t        exp;
    } step_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        br_less, br_equal, mem_ack;
    logic        mem_req, addr_sel, mem_wren, ir_wren, pc_wren, br_sel, br_unsigned;
    logic        rd_wren, op_a_sel, op_b_sel, l_unsigned, insn_illegal, instr_done;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel, s_length;
    logic [2:0]  l_length;

    ctl_t  got;
    step_t sched[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    assign got = {mem_req, addr_sel, mem_wren, ir_wren, pc_wren, br_sel, br_unsigned,
                  rd_wren, op_a_sel, op_b_sel, alu_op, wb_sel, l_length, l_unsigned,
                  s_length, insn_illegal, instr_done};

    mc_ctrl_fsm #(.RESET_WAIT(1)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_instr        (instr),
        .i_br_less      (br_less),
        .i_br_equal     (br_equal),
        .i_mem_ack      (mem_ack),
        .o_mem_req      (mem_req),
        .o_addr_sel     (addr_sel),
        .o_mem_wren     (mem_wren),
        .o_ir_wren      (ir_wren),
        .o_pc_wren      (pc_wren),
        .o_br_sel       (br_sel),
        .o_br_unsigned  (br_unsigned),
        .o_rd_wren      (rd_wren),
        .o_op_a_sel     (op_a_sel),
        .o_op_b_sel     (op_b_sel),
        .o_alu_op       (alu_op),
        .o_wb_sel       (wb_sel),
        .o_l_length     (l_length),
        .o_l_unsigned   (l_unsigned),
        .o_s_length     (s_length),
        .o_insn_illegal (insn_illegal),
        .o_instr_done   (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- checks
    task automatic check_vec(input string tag, input int cyc, input ctl_t exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s[%0d]: outputs %h, expected %h", tag, cyc, got, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // --------------------------------------------------------- reference model
    function automatic logic ref_known(input logic [6:0] op);
        return op == OP_R || op == OP_IMM || op == OP_LOAD || op == OP_STORE ||
               op == OP_BRANCH || op == OP_JAL || op == OP_JALR ||
               op == OP_LUI || op == OP_AUIPC;
    endfunction

    function automatic logic ref_legal(input logic [31:0] ins);
        if (!ref_known(ins[6:0])) return 1'b0;
        if (ins[6:0] == OP_R) return ins[31:25] == 7'h00 || ins[31:25] == 7'h20;
        if (ins[6:0] == OP_BRANCH) return ins[14:12] != 3'd2 && ins[14:12] != 3'd3;
        return 1'b1;
    endfunction

    function automatic logic [3:0] ref_alu(input logic [31:0] ins);
        logic [3:0] by_f3 [8];
        by_f3 = '{4'b0000, 4'b0111, 4'b0010, 4'b0011, 4'b0100, 4'b1000, 4'b0101, 4'b0110};
        if (ins[6:0] == OP_LUI) return 4'b1010;
        if (ins[6:0] != OP_R && ins[6:0] != OP_IMM) return 4'b0000;
        if (ins[30] && ins[14:12] == 3'b101) return 4'b1001;
        if (ins[30] && ins[14:12] == 3'b000 && ins[6:0] == OP_R) return 4'b0001;
        return by_f3[ins[14:12]];
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [31:0] ins, input int fw, input int mw);
        if (!ref_legal(ins)) return 3 + fw;
        if (ins[6:0] == OP_LOAD) return 5 + fw + mw;
        if (ins[6:0] == OP_STORE) return 4 + fw + mw;
        return 4 + fw;
    endfunction

    function automatic step_t rand_step(input logic [31:0] ins);
        step_t s;
        s       = '0;
        s.instr = ins;
        s.ack   = 1'($urandom_range(0, 1));
        s.eq    = 1'($urandom_range(0, 1));
        s.lt    = 1'($urandom_range(0, 1));
        return s;
    endfunction

    // Append the cycles of one instruction to sched. fw / mw are the ack
    // delays of the fetch and data accesses.
    task automatic build(input logic [31:0] ins, input int fw, input int mw,
                         input logic force_br, input logic f_eq, input logic f_lt);
        step_t      s;
        ctl_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic       is_ld, is_st, is_jump, taken;
        op      = ins[6:0];
        f3      = ins[14:12];
        is_ld   = (op == OP_LOAD);
        is_st   = (op == OP_STORE);
        is_jump = (op == OP_JAL) || (op == OP_JALR);

        // fetch: IR is not yet valid, so present junk on i_instr
        for (int k = 0; k <= fw; k++) begin
            s         = rand_step($urandom());
            s.ack     = (k == fw);
            e         = '0;
            e.mem_req = 1'b1;
            e.ir_wren = (k == fw);
            s.exp     = e;
            sched.push_back(s);
        end

        // decode
        s              = rand_step(ins);
        e              = '0;
        e.insn_illegal = !ref_legal(ins);
        s.exp          = e;
        sched.push_back(s);

        if (!ref_legal(ins)) begin
            s              = rand_step(ins);
            e              = '0;
            e.pc_wren      = 1'b1;
            e.instr_done   = 1'b1;
            s.exp          = e;
            sched.push_back(s);
            return;
        end

        // exec
        s = rand_step(ins);
        if (force_br) begin
            s.eq = f_eq;
            s.lt = f_lt;
        end
        e             = '0;
        e.op_a_sel    = (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_AUIPC);
        e.op_b_sel    = (op != OP_R);
        e.alu_op      = ref_alu(ins);
        e.br_unsigned = (op == OP_BRANCH) && f3[1];
        s.exp         = e;
        sched.push_back(s);
        taken = is_jump || ((op == OP_BRANCH) && ref_taken(f3, s.eq, s.lt));

        // mem
        if (is_ld || is_st) begin
            for (int k = 0; k <= mw; k++) begin
                s          = rand_step(ins);
                s.ack      = (k == mw);
                e          = '0;
                e.mem_req  = 1'b1;
                e.addr_sel = 1'b1;
                e.op_b_sel = 1'b1;
                if (is_st) begin
                    e.mem_wren   = 1'b1;
                    e.s_length   = f3[1:0];
                    e.pc_wren    = (k == mw);
                    e.instr_done = (k == mw);
                end else begin
                    e.l_length   = f3;
                    e.l_unsigned = (f3 == 3'b100) || (f3 == 3'b101);
                end
                s.exp = e;
                sched.push_back(s);
            end
            if (is_st) return;
        end

        // writeback
        s            = rand_step(ins);
        e            = '0;
        e.pc_wren    = 1'b1;
        e.br_sel     = taken;
        e.rd_wren    = (op != OP_BRANCH);
        e.wb_sel     = is_ld ? 2'b01 : (is_jump ? 2'b10 : 2'b00);
        e.instr_done = 1'b1;
        if (is_ld) begin
            e.l_length   = f3;
            e.l_unsigned = (f3 == 3'b100) || (f3 == 3'b101);
        end
        s.exp = e;
        sched.push_back(s);
    endtask

    function automatic logic [31:0] gen_instr(input int kind);
        logic [31:0] r;
        r = $urandom();
        case (kind)
            0: begin r[6:0] = OP_R; r[31:25] = r[31] ? 7'b0100000 : 7'b0000000; end
            1: begin r[6:0] = OP_R; r[25] = 1'b1; end
            2: r[6:0] = OP_IMM;
            3: r[6:0] = OP_LOAD;
            4: r[6:0] = OP_STORE;
            5: begin
                r[6:0] = OP_BRANCH;
                while (r[14:13] == 2'b01) r[14:12] = 3'($urandom_range(0, 7));
            end
            6: begin r[6:0] = OP_BRANCH; r[14:13] = 2'b01; end
            7: r[6:0] = OP_JAL;
            8: r[6:0] = OP_JALR;
            9: r[6:0] = OP_LUI;
            10: r[6:0] = OP_AUIPC;
            default: while (ref_known(r[6:0])) r[6:0] = 7'($urandom());
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------- driving
    task automatic run_sched(input string tag, output int done_at);
        done_at = -1;
        foreach (sched[i]) begin
            @(negedge clk);
            mem_ack  = sched[i].ack;
            br_equal = sched[i].eq;
            br_less  = sched[i].lt;
            instr    = sched[i].instr;
            #1;
            check_vec(tag, i, sched[i].exp);
            if (instr_done === 1'b1 && done_at < 0) done_at = i;
        end
        sched.delete();
    endtask

    task automatic run_one(input string tag, input logic [31:0] ins, input int fw,
                           input int mw, input logic force_br, input logic f_eq,
                           input logic f_lt, input int exp_latency);
        int done_at;
        build(ins, fw, mw, force_br, f_eq, f_lt);
        run_sched(tag, done_at);
        check_int({tag, "_latency"}, done_at + 1, exp_latency);
    endtask

    // Release reset on a falling edge with a stray ack pending; the first
    // rising edge must leave the block in IDLE, the second starts FETCH.
    task automatic release_reset();
        @(negedge clk);
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        #1;
        check_vec("idle_after_release", 0, '0);
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        logic [31:0] ins;
        int          fw, mw;
        ctl_t        fetch_v;

        rst_n    = 1'b0;
        instr    = '0;
        br_less  = 1'b0;
        br_equal = 1'b0;
        mem_ack  = 1'b0;

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_ack  = k[0];
            instr    = $urandom();
            br_equal = 1'b1;
            br_less  = 1'b1;
            #1;
            check_vec("in_reset", k, '0);
        end
        release_reset();

        run_one("add",      32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0, 4);
        run_one("lw_wait3", 32'h0000A283, 0, 3, 1'b0, 1'b0, 1'b0, 8);
        run_one("sw",       32'h0050A223, 0, 0, 1'b0, 1'b0, 1'b0, 4);
        run_one("beq_eq",   32'h00000463, 0, 0, 1'b1, 1'b1, 1'b0, 4);
        run_one("beq_ne",   32'h00000463, 0, 0, 1'b1, 1'b0, 1'b1, 4);
        run_one("zero_ins", 32'h00000000, 0, 0, 1'b0, 1'b0, 1'b0, 3);
        run_one("add_fw2",  32'h002081B3, 2, 0, 1'b0, 1'b0, 1'b0, 6);

        for (int n = 0; n < 150; n++) begin
            ins = gen_instr($urandom_range(0, 11));
            fw  = $urandom_range(0, 3);
            mw  = $urandom_range(0, 3);
            run_one("rand", ins, fw, mw, 1'b0, 1'b0, 1'b0, ref_latency(ins, fw, mw));
        end

        // Reset in the middle of a fetch that is still waiting for its ack.
        fetch_v         = '0;
        fetch_v.mem_req = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        instr   = $urandom();
        #1;
        check_vec("fetch_waiting", 0, fetch_v);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("async_reset", 0, '0);
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        check_vec("held_reset", 0, '0);
        release_reset();
        run_one("add_after_reset", 32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0, 4);
        run_one("lw_after_reset",  32'h0000A283, 1, 0, 1'b0, 1'b0, 1'b0, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
